// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the MEM-stage data-memory initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   localparam logic [3:0] BYTE_MASK = 4'b0001;
   localparam logic [3:0] HALF_MASK = 4'b0011;
   localparam logic [3:0] WORD_MASK = 4'b1111;

   // Unaligned base mask for an access width; unknown codes behave as words.
   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      logic [3:0] m;
      case (funct3)
         LB, LBU: m = BYTE_MASK;
         LH, LHU: m = HALF_MASK;
         default: m = WORD_MASK;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] off);
      logic mis;
      case (funct3)
         LB, LBU: mis = 1'b0;
         LH, LHU: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_mask_gen.sv
// ============================================================================
// Module      : dmem_mask_gen
// Description : Byte-lane masks and store-data replication for one access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_mask_gen
   import rv32i_types::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] store_data,
   input  logic        is_store,
   output logic [3:0]  rmask,
   output logic [3:0]  wmask,
   output logic [31:0] wdata
);

   logic [3:0] w_lane_mask;

   // Shift happens in a 4-bit context so lanes past byte 3 are dropped.
   assign w_lane_mask = size_mask(funct3) << off;

   always_comb begin
      rmask = 4'b0000;
      wmask = 4'b0000;
      wdata = '0;
      if (is_store) begin
         wmask = w_lane_mask;
         case (funct3)
            SB:      wdata = {4{store_data[7:0]}};
            SH:      wdata = {2{store_data[15:0]}};
            default: wdata = store_data;
         endcase
      end else begin
         rmask = w_lane_mask;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage load/store initiator; optional MISALIGN_CHECK_EN
//               suppresses misaligned accesses and flags them on misalign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_unit
   import rv32i_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic              advance,
   output logic              mem_stall,
   output logic [ADDR_W-1:0] dmem_address,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [3:0]        dmem_rmask,
   output logic [3:0]        dmem_wmask,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_resp,
   output logic [DATA_W-1:0] rdata_q
`ifdef MISALIGN_CHECK_EN
   ,
   output logic              misalign
`endif
);

   dmem_state_t       r_state;
   dmem_state_t       w_state_next;

   logic [ADDR_W-1:0] r_dmem_address;
   logic              r_dmem_read;
   logic              r_dmem_write;
   logic [3:0]        r_dmem_rmask;
   logic [3:0]        r_dmem_wmask;
   logic [DATA_W-1:0] r_dmem_wdata;
   logic [DATA_W-1:0] r_rdata_q;

   logic              w_mem_req;
   logic              w_misaligned;
   logic              w_accept;
   logic [3:0]        w_rmask;
   logic [3:0]        w_wmask;
   logic [DATA_W-1:0] w_wdata;

   assign w_mem_req = req_valid & (mem_read | mem_write);

`ifdef MISALIGN_CHECK_EN
   assign w_misaligned = is_misaligned(funct3, addr[1:0]);
   assign misalign     = (r_state == IDLE) & w_mem_req & w_misaligned;
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_accept = (r_state == IDLE) & w_mem_req & ~w_misaligned;

   // A request with both strobes set is formatted and issued as a store.
   dmem_mask_gen u_mask_gen (
      .funct3     (funct3),
      .off        (addr[1:0]),
      .store_data (store_data),
      .is_store   (mem_write),
      .rmask      (w_rmask),
      .wmask      (w_wmask),
      .wdata      (w_wdata)
   );

   always_comb begin
      w_state_next = r_state;
      mem_stall    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_req) begin
               mem_stall    = 1'b1;
               w_state_next = w_misaligned ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (dmem_resp) begin
               w_state_next = advance ? IDLE : DONE;
            end else begin
               mem_stall = 1'b1;
            end
         end
         DONE: begin
            if (advance) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_dmem_address <= '0;
         r_dmem_read    <= 1'b0;
         r_dmem_write   <= 1'b0;
         r_dmem_rmask   <= 4'b0000;
         r_dmem_wmask   <= 4'b0000;
         r_dmem_wdata   <= '0;
         r_rdata_q      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_dmem_address <= {addr[ADDR_W-1:2], 2'b00};
            r_dmem_read    <= ~mem_write;
            r_dmem_write   <= mem_write;
            r_dmem_rmask   <= w_rmask;
            r_dmem_wmask   <= w_wmask;
            r_dmem_wdata   <= w_wdata;
         end else if ((r_state == BUSY) && dmem_resp) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (r_dmem_read) begin
               r_rdata_q <= dmem_rdata;
            end
         end
      end
   end

   assign dmem_address = r_dmem_address;
   assign dmem_read    = r_dmem_read;
   assign dmem_write   = r_dmem_write;
   assign dmem_rmask   = r_dmem_rmask;
   assign dmem_wmask   = r_dmem_wmask;
   assign dmem_wdata   = r_dmem_wdata;
   assign rdata_q      = r_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Self-checking bench for dmem_access_unit against a lane model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, mem_read, mem_write, advance;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        mem_stall;
   logic [31:0] dmem_address, dmem_wdata, dmem_rdata, rdata_q;
   logic        dmem_read, dmem_write, dmem_resp;
   logic [3:0]  dmem_rmask, dmem_wmask;
`ifdef MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_rdata_q;
   logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   logic [2:0]  st_codes [3] = '{3'b000, 3'b001, 3'b010};

   always #5 clk = ~clk;

   dmem_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .addr         (addr),
      .store_data   (store_data),
      .advance      (advance),
      .mem_stall    (mem_stall),
      .dmem_address (dmem_address),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_rmask   (dmem_rmask),
      .dmem_wmask   (dmem_wmask),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .rdata_q      (rdata_q)
`ifdef MISALIGN_CHECK_EN
      ,
      .misalign     (misalign)
`endif
   );

   // Reference model: access width in bytes and lanes touched.
   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] off);
      int m;
      m = ((1 << nbytes(f3)) - 1) << off;
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (nbytes(f3) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
      if (nbytes(f3) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef MISALIGN_CHECK_EN
      return (int'(off) % nbytes(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic idle_inputs();
      req_valid = 0; mem_read = 0; mem_write = 0; advance = 0;
      funct3 = 0; addr = 0; store_data = 0; dmem_resp = 0; dmem_rdata = 0;
   endtask

   // One memory op from IDLE; called and returns at posedge+1.
   // done_cycles: cycles held in DONE with advance=0 before the advancing cycle.
   task automatic run_op(input bit is_st, input bit both, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int waits, input int done_cycles, input string tag);
      bit          mis;
      logic [3:0]  em;
      logic [31:0] ew;
      mis = model_mis(f3, a[1:0]);
      em  = model_mask(f3, a[1:0]);
      ew  = model_wdata(f3, sd);
      req_valid = 1; mem_read = !is_st || both; mem_write = is_st;
      funct3 = f3; addr = a; store_data = sd; advance = 0; dmem_resp = 0;
      @(negedge clk);
      n_checks++;
      if (mem_stall !== 1'b1 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL %s issue_cycle: stall/rd/wr got %b%b%b expected 100", tag, mem_stall, dmem_read, dmem_write);
      end
`ifdef MISALIGN_CHECK_EN
      n_checks++;
      if (misalign !== mis) begin
         n_fail++;
         $display("FAIL %s misalign: got %b expected %b", tag, misalign, mis);
      end
`endif
      @(posedge clk); #1;
      if (!mis) begin
         for (int w = 0; w <= waits; w++) begin
            dmem_resp  = (w == waits);
            dmem_rdata = rd;
            advance    = (w == waits) && (done_cycles == 0);
            n_checks++;
            if (dmem_address !== {a[31:2], 2'b00} || dmem_read !== !is_st || dmem_write !== is_st ||
                dmem_rmask !== (is_st ? 4'b0 : em) || dmem_wmask !== (is_st ? em : 4'b0) ||
                (is_st && dmem_wdata !== ew)) begin
               n_fail++;
               $display("FAIL %s bus_cycle%0d: got a=%h r=%b w=%b rm=%b wm=%b wd=%h expected a=%h r=%b w=%b m=%b wd=%h",
                        tag, w, dmem_address, dmem_read, dmem_write, dmem_rmask, dmem_wmask, dmem_wdata,
                        {a[31:2], 2'b00}, !is_st, is_st, em, ew);
            end
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (w != waits)) begin
               n_fail++;
               $display("FAIL %s busy_stall%0d: got %b expected %b", tag, w, mem_stall, (w != waits));
            end
            @(posedge clk); #1;
         end
         if (!is_st) exp_rdata_q = rd;
      end
      dmem_resp = 0;
      if (mis || done_cycles > 0) begin
         for (int d = 0; d <= done_cycles; d++) begin
            advance = (d == done_cycles);
            @(negedge clk);
            n_checks++;
            if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
               n_fail++;
               $display("FAIL %s done%0d: stall/rd/wr got %b%b%b expected 000", tag, d, mem_stall, dmem_read, dmem_write);
            end
`ifdef MISALIGN_CHECK_EN
            n_checks++;
            if (misalign !== 1'b0) begin
               n_fail++;
               $display("FAIL %s misalign_done%0d: got %b expected 0", tag, d, misalign);
            end
`endif
            @(posedge clk); #1;
         end
      end
      n_checks++;
      if (rdata_q !== exp_rdata_q || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after: rdata_q=%h rd=%b wr=%b expected rdata_q=%h rd=0 wr=0", tag, rdata_q, dmem_read, dmem_write, exp_rdata_q);
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      exp_rdata_q = 32'h0;
      @(negedge clk);
      n_checks++;
      if (mem_stall !== 0 || dmem_read !== 0 || dmem_write !== 0 || dmem_rmask !== 0 ||
          dmem_wmask !== 0 || dmem_address !== 0 || dmem_wdata !== 0 || rdata_q !== 0) begin
         n_fail++;
         $display("FAIL reset_state: got st=%b r=%b w=%b rm=%b wm=%b a=%h wd=%h q=%h expected all 0",
                  mem_stall, dmem_read, dmem_write, dmem_rmask, dmem_wmask, dmem_address, dmem_wdata, rdata_q);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sb();
      run_op(1, 0, 3'b000, 32'h1000_0003, 32'hAABB_CCDD, 32'h0, 3, 0, "sb_wait3");
   endtask

   task automatic test_lh();
      run_op(0, 0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, "lh_0wait");
      n_checks++;
      if (rdata_q !== 32'h8001_1234) begin
         n_fail++;
         $display("FAIL lh_rdata_q: got %h expected 80011234", rdata_q);
      end
   endtask

   task automatic test_lw_done();
      run_op(0, 0, 3'b010, 32'h0000_4440, 32'h0, 32'h1357_9BDF, 1, 3, "lw_done3");
   endtask

   task automatic test_reset_mid();
      req_valid = 1; mem_write = 1; mem_read = 0; funct3 = 3'b010;
      addr = 32'h0000_0100; store_data = 32'hCAFE_F00D;
      @(posedge clk); #1;
      n_checks++;
      if (dmem_write !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_busy: dmem_write got %b expected 1", dmem_write);
      end
      rst_n = 0; idle_inputs();
      @(posedge clk); #1;
      rst_n = 1; dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
      exp_rdata_q = 32'h0;
      @(negedge clk);
      n_checks++;
      if (mem_stall !== 0 || dmem_write !== 0 || dmem_address !== 0 || dmem_wmask !== 0 || dmem_wdata !== 0) begin
         n_fail++;
         $display("FAIL rstmid_cleared: st=%b w=%b a=%h wm=%b wd=%h expected all 0",
                  mem_stall, dmem_write, dmem_address, dmem_wmask, dmem_wdata);
      end
      @(posedge clk); #1;
      dmem_resp = 0;
      n_checks++;
      if (rdata_q !== 0 || dmem_read !== 0 || dmem_write !== 0 || dmem_rmask !== 0) begin
         n_fail++;
         $display("FAIL rstmid_late_resp: q=%h r=%b w=%b rm=%b expected 0", rdata_q, dmem_read, dmem_write, dmem_rmask);
      end
   endtask

   task automatic test_non_mem();
      for (int i = 0; i < 3; i++) begin
         req_valid = 1; mem_read = 0; mem_write = 0; advance = 1;
         addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
         @(negedge clk);
         n_checks++;
         if (mem_stall !== 0 || dmem_read !== 0 || dmem_write !== 0) begin
            n_fail++;
            $display("FAIL nonmem%0d: stall/rd/wr got %b%b%b expected 000", i, mem_stall, dmem_read, dmem_write);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      run_op(1, 0, 3'b010, 32'h0000_0010, 32'h0102_0304, 32'h0, 0, 0, "b2b_sw");
      run_op(0, 0, 3'b100, 32'h0000_0013, 32'h0, 32'hF0E1_D2C3, 0, 0, "b2b_lbu");
   endtask

`ifdef MISALIGN_CHECK_EN
   task automatic test_misalign();
      run_op(1, 0, 3'b010, 32'h0000_2001, 32'h5555_AAAA, 32'h0, 0, 2, "mis_sw");
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         bit         st;
         bit         both;
         logic [2:0] f3;
         st   = 1'($urandom_range(0, 1));
         both = st && ($urandom_range(0, 7) == 0);
         f3   = st ? st_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
         run_op(st, both, f3, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_sb();
      test_lh();
      test_lw_done();
      test_reset_mid();
      test_non_mem();
      test_back_to_back();
`ifdef MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Memory-stage data-memory initiator. It converts load and store requests from the EX/MEM buffer into word-aligned dmem read and write transactions: byte lanes, masks and store-data replication. It holds each request stable until dmem_resp and stalls the pipeline meanwhile. It captures the returned word so the write-back stage can extract the load from it.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width; fixed at 32, 4 byte lanes

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  a valid instruction occupies the MEM stage
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
funct3  in  3  load/store width code (rv32i funct3 encoding)
addr  in  ADDR_W  effective byte address from ALU
store_data  in  DATA_W  rs2 value
advance  in  1  MEM->WB buffer loads this cycle
mem_stall  out  1  hold pipeline; combinational
dmem_address  out  ADDR_W  word-aligned address; registered
dmem_read  out  1  read strobe; registered
dmem_write  out  1  write strobe; registered
dmem_rmask  out  4  read byte mask; registered
dmem_wmask  out  4  write byte mask; registered
dmem_wdata  out  DATA_W  lane-replicated store data; registered
dmem_rdata  in  DATA_W  read data, valid with dmem_resp
dmem_resp  in  1  transaction complete
rdata_q  out  DATA_W  captured read word for WB
misalign  out  1  misaligned access pulse; present only with MISALIGN_CHECK_EN

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. dmem_read, dmem_write, masks, dmem_address, dmem_wdata and rdata_q all 0. Reset mid-transaction drops the request; a late dmem_resp in IDLE is ignored.
- Address: dmem_address = {addr[31:2],2'b00}. Offset off = addr[1:0].
- Store formatting:
  - sb: wdata = {4{rs[7:0]}}, wmask = 4'b0001<<off.
  - sh: wdata = {2{rs[15:0]}}, wmask = 4'b0011<<off.
  - sw: wdata = rs, wmask = 4'b1111.
  - Shifts are truncated to 4 bits.
- Load masks: lb/lbu use 4'b0001<<off; lh/lhu use 4'b0011<<off; lw uses 4'b1111. wmask=0 on loads; rmask=0 on stores.
- mem_read and mem_write both set is illegal; treat as a store.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on req_valid & (mem_read|mem_write), register strobe/mask/address/data and go to BUSY. Strobes go high on the next cycle, so there is 1 cycle of issue latency.
  - BUSY: all dmem outputs held stable. On dmem_resp: strobes drop at the next edge and rdata_q <= dmem_rdata (stores leave rdata_q unchanged). Next state is IDLE if advance, else DONE.
  - DONE: strobes low. Wait for advance, then go to IDLE. The same request is never reissued.
- mem_stall = (IDLE & req_valid & (mem_read|mem_write)) | (BUSY & ~dmem_resp).
- Minimum load/store latency is 2 cycles with a 0-wait-state memory.
- Non-memory instructions with advance=1 pass through IDLE with no stall.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after the first completes, giving one idle bus cycle between them.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: a misaligned access is any halfword with off=3 or off[0]=1, or any word with off!=0.
  - No dmem transaction is issued.
  - misalign pulses for 1 cycle; the FSM goes IDLE->DONE directly with mem_stall=1 for that one cycle.
  - rdata_q is unchanged.
- Undefined: the misalign port is absent. Masks are truncated as above and the access is issued as-is.

Decomposition:
- rv32i_types package:
  - dmem_state_t enum {IDLE,BUSY,DONE}.
  - load_funct3_t and store_funct3_t enums, reused.
  - Mask constants BYTE_MASK=4'b0001, HALF_MASK=4'b0011, WORD_MASK=4'b1111.
- One combinational sub-module, dmem_mask_gen: (funct3, off, store_data, is_store) -> (rmask, wmask, wdata).

Test Plan:
- sb, addr=0x1000_0003, rs2=0xAABBCCDD, resp after 3 cycles: dmem_address=0x1000_0000, wmask=4'b1000, wdata=0xDDDDDDDD; mem_stall high 4 cycles; strobe held stable.
- lh, addr=0x2002, dmem_rdata=0x8001_1234, 0-wait memory: rmask=4'b1100, rdata_q=0x80011234 next cycle; total stall 1 cycle; no reissue.
- lw completes with advance=0 for 3 cycles: FSM in DONE; dmem_read low; mem_stall=0; exactly one dmem_read burst observed.
- rst_n=0 while BUSY (sw in flight), then dmem_resp=1 in IDLE: outputs 0, no state change, rdata_q=0.
- Back-to-back sw 0x10 then lbu 0x13: two separate transactions, wmask=4'b1111 then rmask=4'b1000, one idle bus cycle between them.
- [MISALIGN_CHECK_EN] sw to 0x2001: no dmem_write; misalign=1 for one cycle; then DONE awaiting advance.
